// File: rtl/munoc_xmi_burst_pkg.sv
// munoc_xmi_burst_pkg: shared state encoding, AXI constants and dready bit indices
package munoc_xmi_burst_pkg;
  typedef enum logic [2:0] {IDLE, RREQ, WBEAT, RWAIT, BWAIT} state_t;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int RD_IDX = 0;
  localparam int WR_IDX = 1;
endpackage

// File: rtl/munoc_xmi_beat_counter.sv
// munoc_xmi_beat_counter: loadable up-counter with an at-limit flag
module munoc_xmi_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         at_limit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (inc) cnt <= cnt + 1'b1;
  assign at_limit = cnt == limit;
endmodule

// File: rtl/munoc_xmi_burst_requester.sv
// munoc_xmi_burst_requester: burst command to XMI rlxq/rlxy beats; optional watchdog via MUNOC_XMI_BURST_REQUESTER_TIMEOUT_EN
module munoc_xmi_burst_requester
  import munoc_xmi_burst_pkg::*;
#(
  parameter int BW_ADDR   = 32,
  parameter int BW_DATA   = 32,
  parameter int BW_BURDEN = 1,
  parameter int MAX_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [BW_ADDR-1:0]   cmd_addr,
  input  logic [7:0]           cmd_len,
  input  logic [2:0]           cmd_size,
  input  logic [BW_BURDEN-1:0] cmd_burden,
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [BW_DATA-1:0]   wd_data,
  input  logic [BW_DATA/8-1:0] wd_strb,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [BW_DATA-1:0]   rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic [1:0]           done_resp,
  input  logic [1:0]           rlxqdready,
  output logic                 rlxqvalid,
  output logic                 rlxqlast,
  output logic                 rlxqwrite,
  output logic [7:0]           rlxqlen,
  output logic [2:0]           rlxqsize,
  output logic [1:0]           rlxqburst,
  output logic [BW_DATA/8-1:0] rlxqwstrb,
  output logic [BW_DATA-1:0]   rlxqwdata,
  output logic [BW_ADDR-1:0]   rlxqaddr,
  output logic [BW_BURDEN-1:0] rlxqburden,
  output logic [1:0]           rlxydready,
  input  logic                 rlxyvalid,
  input  logic                 rlxylast,
  input  logic                 rlxywreply,
  input  logic [1:0]           rlxyresp,
  input  logic [BW_DATA-1:0]   rlxyrdata,
  input  logic [BW_BURDEN-1:0] rlxyburden
);
  state_t state, state_n;
  logic [BW_ADDR-1:0] addr_q;
  logic [7:0] len_q;
  logic [2:0] size_q;
  logic [BW_BURDEN-1:0] burden_q;
  logic [1:0] worst_q, worst_n, resp_q, resp_fin;
  logic bad_q, bad_n, accept, q_hs, y_hs, fin, to, at_limit, req;
  assign accept = cmd_valid & cmd_ready;
  assign cmd_ready = (state == IDLE) & ~rstnn;
  assign q_hs = rlxqvalid & rlxqdready[rlxqwrite];
  assign y_hs = rlxyvalid & rlxydready[rlxywreply];
  assign fin = y_hs & ((state == BWAIT) | rlxylast);
  assign req = (state == RREQ) | (state == WBEAT);
  assign worst_n = (y_hs && rlxyresp > worst_q) ? rlxyresp : worst_q;
  assign bad_n = bad_q | (y_hs & (rlxyburden != burden_q));
  assign resp_fin = to ? DECERR : bad_n ? SLVERR : (state == BWAIT) ? rlxyresp : worst_n;
  assign done = (fin | to) & ~rstnn;
  assign done_resp = done ? resp_fin : resp_q;
  munoc_xmi_beat_counter #(.W(8)) u_beats (
    .clk(clk), .rst(rstnn), .load(accept), .init(8'd0),
    .inc((state == WBEAT) & q_hs), .limit(len_q), .at_limit(at_limit)
  );
`ifdef MUNOC_XMI_BURST_REQUESTER_TIMEOUT_EN
  logic [15:0] wdog_q;
  always_ff @(posedge clk)
    if (rstnn || state == IDLE || q_hs || y_hs) wdog_q <= '0;
    else wdog_q <= wdog_q + 16'd1;
  assign to = (state != IDLE) & (&wdog_q) & ~q_hs & ~y_hs;
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rstnn) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burden_q <= '0;
      worst_q  <= OKAY;
      bad_q    <= 1'b0;
      resp_q   <= OKAY;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len >= 8'(MAX_LEN) ? 8'(MAX_LEN - 1) : cmd_len;
        size_q   <= cmd_size;
        burden_q <= cmd_burden;
        worst_q  <= OKAY;
        bad_q    <= 1'b0;
      end else begin
        worst_q <= worst_n;
        bad_q   <= bad_n;
      end
      if (done) resp_q <= resp_fin;
    end
  end
  // write direction lives in the state itself, so no separate write flag is kept
  always_comb begin
    state_n = (fin | to) ? IDLE :
              accept ? (cmd_write ? WBEAT : RREQ) :
              (state == RREQ && q_hs) ? RWAIT :
              (state == WBEAT && q_hs && at_limit) ? BWAIT : state;
    rlxqvalid  = (state == RREQ) | ((state == WBEAT) & wd_valid);
    rlxqwrite  = state == WBEAT;
    rlxqlast   = (state == RREQ) | ((state == WBEAT) & at_limit);
    rlxqwdata  = (state == WBEAT) ? wd_data : '0;
    rlxqwstrb  = (state == WBEAT) ? wd_strb : '0;
    rlxqlen    = req ? len_q : '0;
    rlxqsize   = req ? size_q : '0;
    rlxqburst  = req ? INCR : 2'b00;
    rlxqaddr   = req ? addr_q : '0;
    rlxqburden = req ? burden_q : '0;
    wd_ready   = (state == WBEAT) & rlxqdready[WR_IDX];
    rlxydready = '0;
    rlxydready[RD_IDX] = (state == RWAIT) & rd_ready;
    rlxydready[WR_IDX] = state == BWAIT;
    rd_valid   = (state == RWAIT) & rlxyvalid & ~rlxywreply;
    rd_data    = (state == RWAIT) ? rlxyrdata : '0;
    rd_last    = (state == RWAIT) & rlxylast;
  end
endmodule

// File: doc/munoc_xmi_burst_requester.md
Name: munoc_xmi_burst_requester

Overview:
- Upstream command engine that feeds the rlxq/rlxy request–reply stream of the XMI master network interface.
- Turns a single burst command plus a write-data stream into correctly framed XMI request beats.
- Collects reply beats and returns read data and a completion status to the local agent, e.g. a DMA or accelerator control unit.
- At most one transaction is in flight.

Parameters:
- BW_ADDR, 32, request address width; equals the platform address width.
- BW_DATA, 32, data width; strobe width is BW_DATA/8.
- BW_BURDEN, 1, sideband burden width; replies must echo it.
- MAX_LEN, 16, maximum beats per burst; cmd_len is limited to MAX_LEN-1.

Ports:
- clk  in  1  clock.
- rstnn  in  1  synchronous, active-high reset (1 = reset).
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  BW_ADDR  start address.
- cmd_len  in  8  beats minus 1 (AXI ALEN encoding).
- cmd_size  in  3  AXI ASIZE.
- cmd_burden  in  BW_BURDEN  sideband tag.
- wd_valid / wd_ready  in / out  1  write-data handshake.
- wd_data  in  BW_DATA  write data.
- wd_strb  in  BW_DATA/8  write strobe.
- rd_valid / rd_ready  out / in  1  read-data handshake.
- rd_data  out  BW_DATA  read data.
- rd_last  out  1  final read beat.
- done  out  1  one-cycle completion pulse.
- done_resp  out  2  final AXI response, held until the next done.
- rlxqdready  in  2  downstream ready: [0] read beat, [1] write beat.
- rlxqvalid, rlxqlast, rlxqwrite  out  1 each.
- rlxqlen  out  8.
- rlxqsize  out  3.
- rlxqburst  out  2.
- rlxqwstrb  out  BW_DATA/8.
- rlxqwdata  out  BW_DATA.
- rlxqaddr  out  BW_ADDR.
- rlxqburden  out  BW_BURDEN.
- rlxydready  out  2  reply ready: [0] read reply, [1] write reply.
- rlxyvalid, rlxylast, rlxywreply  in  1 each.
- rlxyresp  in  2.
- rlxyrdata  in  BW_DATA.
- rlxyburden  in  BW_BURDEN.

Behaviour:
- Request beat handshake: rlxqvalid & rlxqdready[rlxqwrite].
- Reply beat handshake: rlxyvalid & rlxydready[rlxywreply].
- Reset values: every output 0; FSM in IDLE; done_resp = 0.
- Registered fields: cmd_write, cmd_addr, cmd_len, cmd_size and cmd_burden are captured on command accept and held for the whole transaction.
- Constant request fields: rlxqburst = INCR (2'b01); rlxqaddr = captured start address on every beat.

FSM states: IDLE, RREQ, WBEAT, RWAIT, BWAIT.
- IDLE:
  - cmd_ready = 1.
  - On accept, go to RREQ (read) or WBEAT (write).
  - A command with cmd_len >= MAX_LEN is still accepted and is clamped to MAX_LEN-1.
- RREQ:
  - Drives one beat: rlxqvalid = 1, rlxqwrite = 0, rlxqlast = 1, rlxqwstrb = 0, rlxqwdata = 0.
  - On handshake, go to RWAIT.
- WBEAT:
  - rlxqvalid = wd_valid; wd_ready = rlxqdready[1]. Data and strobe pass through combinationally, with no buffering.
  - Beat counter runs from 0; rlxqlast = 1 when the counter equals the captured len.
  - On the last handshake, go to BWAIT.
- RWAIT:
  - rlxydready[0] = rd_ready; rd_valid = rlxyvalid & ~rlxywreply.
  - rd_data = rlxyrdata; rd_last = rlxylast.
  - The worst response seen is accumulated by maximum value (SLVERR/DECERR dominate OKAY).
  - On the rlxylast handshake: pulse done, publish done_resp, go to IDLE.
- BWAIT:
  - rlxydready[1] = 1.
  - On the write-reply handshake: done_resp = rlxyresp, pulse done, go to IDLE.
- Burden mismatch: if rlxyburden differs from the captured tag on any reply beat, done_resp is forced to SLVERR (2'b10).
- Stray replies: a reply whose type does not match the current state is not accepted, because the corresponding dready bit stays 0.
- Back-to-back commands: the earliest next cmd_ready is the cycle after done, since IDLE is entered after done. Minimum command-to-command gap is therefore 1 idle cycle.
- Reset mid-transaction: the FSM returns to IDLE in the next cycle with no done pulse; the partial burst is abandoned.

Optional Feature:
- Macro: MUNOC_XMI_BURST_REQUESTER_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog clears on every handshake in RREQ, WBEAT, RWAIT or BWAIT and counts otherwise.
  - When it reaches 16'hFFFF: done pulses, done_resp = DECERR (2'b11), FSM goes to IDLE.
  - Any late replies are afterwards held off, because dready stays 0 in IDLE.
- When not defined: no counter; the block waits indefinitely.

Decomposition:
- Shared package munoc_xmi_burst_pkg holds:
  - state enum;
  - AXI burst and response constants: INCR, OKAY, SLVERR, DECERR;
  - the rlxqdready/rlxydready bit indices RD_IDX = 0 and WR_IDX = 1.
- One natural sub-module, munoc_xmi_beat_counter: loadable up-counter with an at-limit flag, used for the write-beat count. The watchdog, when enabled, uses an inline counter.

Test Plan:
- Read, len = 3, addr 0x1000, rlxqdready = 2'b11: exactly one rlxq beat with last = 1, len = 3, burst = 01. Four replies 0xA0..0xA3 appear on rd_data, rd_last on the 4th beat, done with done_resp = 0.
- Write, len = 1, data 0x11/0x22, strb F: two rlxq beats, write = 1, last on the 2nd only. A wreply with resp OKAY gives done with done_resp = 0.
- Write with rlxqdready[1] toggling every other cycle: wd_ready mirrors it, no beat is lost or duplicated, and the beat count stays 4 for len = 3.
- Read where the 2nd reply has resp = SLVERR: done_resp = 2'b10. A reply with a mismatched burden also gives 2'b10.
- rstnn asserted during WBEAT after 2 of 4 beats: the next cycle shows IDLE, all outputs 0, and no done pulse.
- With TIMEOUT_EN, read with no reply for 65535 cycles: done pulses with done_resp = 2'b11, and cmd_ready = 1 on the next cycle.
